nco_mux_engine: RTL and testbench

// Time-multiplexed phase-accumulator engine for the synth oscillator section: one shared adder

---
 rtl/nco_mux_engine_if.sv | 38 +++
 rtl/nco_mux_engine.sv | 112 +++++++++++
 tb/tb_nco_mux_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/nco_mux_engine_if.sv
// Control/write port and tagged phase stream of the oscillator engine.
// The engine takes the slave side and the wavetable stage or bench takes the master side.
interface nco_mux_engine_if #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int PITCH_W = 24,
    parameter int P_OUT   = 11
);
    logic               enable;
    logic               pitch_we;
    logic [V_WIDTH-1:0] pitch_v;
    logic [O_WIDTH-1:0] pitch_o;
    logic [PITCH_W-1:0] pitch_val;
    logic               offs_we;
    logic [P_OUT-1:0]   offs_val;
    logic               zero_req;
    logic [V_WIDTH-1:0] zero_v;
    logic [O_WIDTH-1:0] zero_o;
    logic [VOICES-1:0]  sync_en;
    logic               out_valid;
    logic [V_WIDTH-1:0] out_v;
    logic [O_WIDTH-1:0] out_o;
    logic [P_OUT-1:0]   out_phase;
    logic               out_wrap;

    modport slave (
        input  enable, pitch_we, pitch_v, pitch_o, pitch_val, offs_we, offs_val,
               zero_req, zero_v, zero_o, sync_en,
        output out_valid, out_v, out_o, out_phase, out_wrap
    );
    modport master (
        output enable, pitch_we, pitch_v, pitch_o, pitch_val, offs_we, offs_val,
               zero_req, zero_v, zero_o, sync_en,
        input  out_valid, out_v, out_o, out_phase, out_wrap
    );
endinterface

// File: rtl/nco_mux_engine.sv
// Round-robin phase accumulator: one shared adder serves VOICES*V_OSC slots, with
// per-slot offset and zero request, per-voice hard sync from osc 0, and a wrap flag.
module nco_mux_engine #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int ACC_W   = 36,
    parameter int PITCH_W = 24,
    parameter int P_OUT   = 11
) (
    input logic              OSC_CLK,
    input logic              reg_reset,
    nco_mux_engine_if.slave  bus
);
    localparam int VI_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int OI_W = (V_OSC > 1) ? $clog2(V_OSC) : 1;
    localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(VOICES - 1);
    localparam logic [O_WIDTH-1:0] O_LAST = O_WIDTH'(V_OSC - 1);

    typedef struct packed {
        logic [VI_W-1:0]  v;
        logic [OI_W-1:0]  o;
        logic [ACC_W-1:0] pitch;
        logic [P_OUT-1:0] offs;
    } slot_t;

    logic [ACC_W-1:0] acc   [VOICES][V_OSC];
    logic [ACC_W-1:0] pitch [VOICES][V_OSC];
    logic [P_OUT-1:0] offs  [VOICES][V_OSC];
    logic             zpend [VOICES][V_OSC];
    logic [VOICES-1:0] sync_flag;
    logic [VI_W-1:0]  cnt_v;
    logic [OI_W-1:0]  cnt_o;
    slot_t            s1;
    logic [1:0]       vld_pipe;

    logic [VI_W-1:0] pv, zv;
    logic [OI_W-1:0] po, zo;
    logic            p_ok, z_ok;
    assign pv   = bus.pitch_v[VI_W-1:0];
    assign po   = bus.pitch_o[OI_W-1:0];
    assign zv   = bus.zero_v[VI_W-1:0];
    assign zo   = bus.zero_o[OI_W-1:0];
    assign p_ok = (bus.pitch_v <= V_LAST) && (bus.pitch_o <= O_LAST);
    assign z_ok = (bus.zero_v <= V_LAST) && (bus.zero_o <= O_LAST);

    // Stage 1: the accumulator is read here, so a slot's previous writeback is always visible.
    logic [ACC_W:0]   sum;
    logic             do_zero;
    logic [ACC_W-1:0] acc_new;
    logic [P_OUT-1:0] ph_new;
    always_comb begin
        sum     = {1'b0, acc[s1.v][s1.o]} + {1'b0, s1.pitch};
        do_zero = zpend[s1.v][s1.o] ||
                  ((s1.o != '0) && bus.sync_en[s1.v] && sync_flag[s1.v]);
        acc_new = do_zero ? '0 : sum[ACC_W-1:0];
        ph_new  = acc_new[ACC_W-1 -: P_OUT] + s1.offs;
    end

    assign bus.out_valid = vld_pipe[1];

    always_ff @(posedge OSC_CLK or posedge reg_reset) begin
        if (reg_reset) begin
            for (int v = 0; v < VOICES; v++)
                for (int o = 0; o < V_OSC; o++) begin
                    acc[v][o]   <= '0;
                    pitch[v][o] <= '0;
                    offs[v][o]  <= '0;
                    zpend[v][o] <= 1'b0;
                end
            sync_flag     <= '0;
            cnt_v         <= '0;
            cnt_o         <= '0;
            s1            <= '0;
            vld_pipe      <= '0;
            bus.out_v     <= '0;
            bus.out_o     <= '0;
            bus.out_phase <= '0;
            bus.out_wrap  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], bus.enable};
            if (bus.enable) begin
                s1.v     <= cnt_v;
                s1.o     <= cnt_o;
                s1.pitch <= pitch[cnt_v][cnt_o];
                s1.offs  <= offs[cnt_v][cnt_o];
                if (cnt_o == OI_W'(V_OSC - 1)) begin
                    cnt_o <= '0;
                    cnt_v <= (cnt_v == VI_W'(VOICES - 1)) ? '0 : cnt_v + 1'b1;
                end else begin
                    cnt_o <= cnt_o + 1'b1;
                end
            end
            if (vld_pipe[0]) begin
                acc[s1.v][s1.o]   <= acc_new;
                zpend[s1.v][s1.o] <= 1'b0;
                // A zeroed osc 0 did not wrap by itself, so it does not trigger sync.
                if (s1.o == '0)
                    sync_flag[s1.v] <= sum[ACC_W] & ~do_zero;
                bus.out_v     <= V_WIDTH'(s1.v);
                bus.out_o     <= O_WIDTH'(s1.o);
                bus.out_phase <= ph_new;
                bus.out_wrap  <= do_zero | sum[ACC_W];
            end
            // Placed after the stage-1 clear so a same-cycle request survives.
            if (bus.zero_req && z_ok) zpend[zv][zo] <= 1'b1;
            if (bus.pitch_we && p_ok) pitch[pv][po] <= ACC_W'(bus.pitch_val);
            if (bus.offs_we && p_ok)  offs[pv][po]  <= bus.offs_val;
        end
    end
endmodule

// File: tb/tb_nco_mux_engine.sv
// Directed bench for nco_mux_engine with 2 voices x 2 oscillators.
module tb_nco_mux_engine;
    localparam int VOICES = 2, V_OSC = 2, V_WIDTH = 3, O_WIDTH = 2;
    localparam int ACC_W = 36, PITCH_W = 36, P_OUT = 11;
    localparam logic [35:0] P25 = 36'd1 << 25;
    localparam logic [35:0] P24 = 36'd1 << 24;
    localparam logic [35:0] P26 = 36'd1 << 26;
    localparam logic [35:0] P34 = 36'd1 << 34;
    localparam logic [35:0] P35 = 36'd1 << 35;

    logic osc_clk = 1'b0;
    logic reg_reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 osc_clk = ~osc_clk;

    nco_mux_engine_if #(.VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
                        .PITCH_W(PITCH_W), .P_OUT(P_OUT)) bus ();

    nco_mux_engine #(.VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
                     .ACC_W(ACC_W), .PITCH_W(PITCH_W), .P_OUT(P_OUT))
        dut (.OSC_CLK(osc_clk), .reg_reset(reg_reset), .bus(bus));

    typedef struct {
        logic [2:0]  v;
        logic [1:0]  o;
        logic [10:0] phase;
        logic        wrap;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge osc_clk);
    endtask

    task automatic idle_inputs;
        bus.pitch_we = 0; bus.offs_we = 0; bus.zero_req = 0;
        bus.pitch_v = 0; bus.pitch_o = 0; bus.pitch_val = 0; bus.offs_val = 0;
        bus.zero_v = 0; bus.zero_o = 0;
    endtask

    task automatic do_reset;
        reg_reset = 1; bus.enable = 0; bus.sync_en = 0;
        idle_inputs();
        tick(); tick();
        reg_reset = 0;
        tick();
    endtask

    task automatic wr(input logic [2:0] v, input logic [1:0] o, input logic [35:0] p,
                      input logic pw, input logic [10:0] f, input logic fw);
        bus.pitch_v = v; bus.pitch_o = o; bus.pitch_val = p; bus.pitch_we = pw;
        bus.offs_val = f; bus.offs_we = fw;
        tick();
        bus.pitch_we = 0; bus.offs_we = 0;
    endtask

    task automatic zreq(input logic [2:0] v, input logic [1:0] o);
        bus.zero_v = v; bus.zero_o = o; bus.zero_req = 1;
        tick();
        bus.zero_req = 0;
    endtask

    task automatic next_valid(output logic ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL next_valid: got timeout want out_valid");
        end
    endtask

    task automatic wait_slot(input logic [2:0] v, input logic [1:0] o, output logic ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid && bus.out_v == v && bus.out_o == o) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_slot(%0d,%0d): got timeout want sample", v, o);
        end
    endtask

    task automatic chk_slot(input string name, input logic [2:0] v, input logic [1:0] o,
                            input logic [10:0] ph, input logic w);
        logic ok;
        wait_slot(v, o, ok);
        if (ok) begin
            chk({name, ".phase"}, bus.out_phase, ph);
            chk({name, ".wrap"}, bus.out_wrap, w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int e01 [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
        int w01 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int e11 [8] = '{0, 1, 1, 2, 2, 3, 3, 4};

        // Expected stream: (0,0) ramps by 1, (1,1) toggles its MSB, the rest stay 0.
        for (int f = 0; f < 3; f++) begin
            tbl[f*4+0] = '{3'd0, 2'd0, 11'(f + 1), 1'b0};
            tbl[f*4+1] = '{3'd0, 2'd1, 11'd0, 1'b0};
            tbl[f*4+2] = '{3'd1, 2'd0, 11'd0, 1'b0};
            tbl[f*4+3] = '{3'd1, 2'd1, (f == 1) ? 11'd0 : 11'd1024, (f == 1)};
        end

        bus.enable = 0; bus.sync_en = 0; idle_inputs();
        tick();
        chk("rst.valid", bus.out_valid, 0);
        chk("rst.phase", bus.out_phase, 0);
        chk("rst.wrap", bus.out_wrap, 0);
        chk("rst.v", bus.out_v, 0);
        chk("rst.o", bus.out_o, 0);

        // Ramp, MSB toggle, and ignored out-of-range writes.
        do_reset();
        wr(3'd2, 2'd1, 36'd1 << 30, 1, 11'd5, 1);
        wr(3'd0, 2'd2, 36'd1 << 30, 1, 11'd5, 1);
        wr(3'd0, 2'd0, P25, 1, 11'd0, 0);
        wr(3'd1, 2'd1, P35, 1, 11'd0, 0);
        bus.enable = 1;
        for (int i = 0; i < 12; i++) begin
            next_valid(ok);
            if (ok) begin
                chk($sformatf("tbl%0d.v", i), bus.out_v, tbl[i].v);
                chk($sformatf("tbl%0d.o", i), bus.out_o, tbl[i].o);
                chk($sformatf("tbl%0d.phase", i), bus.out_phase, tbl[i].phase);
                chk($sformatf("tbl%0d.wrap", i), bus.out_wrap, tbl[i].wrap);
            end
        end

        // Zero request after 10 frames; an out-of-range request beforehand is dropped.
        do_reset();
        wr(3'd0, 2'd1, P25, 1, 11'd0, 0);
        zreq(3'd2, 2'd1);
        bus.enable = 1;
        chk_slot("zero.f1", 0, 1, 11'd1, 0);
        for (int k = 2; k < 10; k++) begin
            wait_slot(0, 1, ok);
        end
        chk_slot("zero.f10", 0, 1, 11'd10, 0);
        zreq(3'd0, 2'd1);
        chk_slot("zero.hit", 0, 1, 11'd0, 1);
        chk_slot("zero.after", 0, 1, 11'd1, 0);

        // Hard sync on voice 0 only.
        do_reset();
        bus.sync_en = 2'b01;
        wr(3'd0, 2'd0, P34, 1, 11'd0, 0);
        wr(3'd0, 2'd1, P24, 1, 11'd0, 0);
        wr(3'd1, 2'd0, P34, 1, 11'd0, 0);
        wr(3'd1, 2'd1, P24, 1, 11'd0, 0);
        bus.enable = 1;
        for (int f = 0; f < 8; f++) begin
            chk_slot($sformatf("sync01.f%0d", f + 1), 0, 1, 11'(e01[f]), w01[f][0]);
            chk_slot($sformatf("sync11.f%0d", f + 1), 1, 1, 11'(e11[f]), 1'b0);
        end

        // Offset addition wraps mod 2^P_OUT; pitch and offset written together.
        do_reset();
        wr(3'd0, 2'd0, P25, 1, 11'd2047, 1);
        wr(3'd0, 2'd1, 36'd0, 0, 11'd1024, 1);
        bus.enable = 1;
        chk_slot("offs.wrap0", 0, 0, 11'd0, 0);
        chk_slot("offs.1024", 0, 1, 11'd1024, 0);
        chk_slot("offs.wrap1", 0, 0, 11'd1, 0);

        // Mid-frame reset aborts outputs at once; then restart and enable gap.
        tick();
        chk("midrst.pre", bus.out_valid, 1);
        reg_reset = 1; bus.enable = 0;
        #1;
        chk("midrst.valid", bus.out_valid, 0);
        chk("midrst.phase", bus.out_phase, 0);
        chk("midrst.v", bus.out_v, 0);
        tick();
        reg_reset = 0;
        tick();
        wr(3'd0, 2'd0, P25, 1, 11'd0, 0);
        wr(3'd1, 2'd0, P26, 1, 11'd0, 0);
        bus.enable = 1;
        tick();
        chk("restart.e1.valid", bus.out_valid, 0);
        tick();
        chk("restart.e2.valid", bus.out_valid, 1);
        chk("restart.e2.v", bus.out_v, 0);
        chk("restart.e2.o", bus.out_o, 0);
        chk("restart.e2.phase", bus.out_phase, 1);
        bus.enable = 0;
        tick();
        chk("hold.e3.valid", bus.out_valid, 1);
        chk("hold.e3.o", bus.out_o, 1);
        tick();
        chk("hold.e4.valid", bus.out_valid, 0);
        tick();
        chk("hold.e5.valid", bus.out_valid, 0);
        bus.enable = 1;
        tick();
        chk("hold.e6.valid", bus.out_valid, 0);
        tick();
        chk("hold.e7.valid", bus.out_valid, 1);
        chk("hold.e7.v", bus.out_v, 1);
        chk("hold.e7.o", bus.out_o, 0);
        chk("hold.e7.phase", bus.out_phase, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
